// File: rtl/mem_arbiter_pkg.sv
// Shared constants and types for the byte-wide external memory arbiter.
package mem_arbiter_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic [1:0] IO_BASE_HI = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWrite
    } state_e;

    typedef enum logic {
        GntIc,
        GntLs
    } grant_e;

    // Undefined size code 2'b11 is treated as a word.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates icache fetches and LSB accesses onto the byte-wide memory bus,
// serialising multi-byte transfers and assembling read data little-endian.
module mem_arbiter #(
    parameter logic [1:0] IO_BASE_HI = mem_arbiter_pkg::IO_BASE_HI
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        flush,
    input  logic        ic_req,
    input  logic [31:0] ic_addr,
    output logic        ic_done,
    output logic [31:0] ic_data,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [1:0]  ls_size,
    input  logic [31:0] ls_wdata,
    output logic        ls_done,
    output logic [31:0] ls_rdata
);
    import mem_arbiter_pkg::*;

    state_e      state_q, state_d;
    grant_e      owner_q, owner_d;
    grant_e      last_grant_q, last_grant_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  nbytes_q, nbytes_d;
    logic [23:0] wdata_q, wdata_d;
    logic [31:0] rbuf_q, rbuf_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic        mem_wr_q, mem_wr_d;
    logic        ic_done_q, ic_done_d;
    logic        ls_done_q, ls_done_d;
    logic [31:0] ic_data_q, ic_data_d;
    logic [31:0] ls_rdata_q, ls_rdata_d;

    logic        ic_elig, ls_elig, grant_ic, grant_ls;
    logic        abort, last_byte, read_end;
    logic [31:0] rd_word;

    // A requester whose done is high this cycle is dropping its request.
    assign ic_elig  = ic_req && !ic_done_q && !flush;
    assign ls_elig  = ls_req && !ls_done_q
                      && !(ls_we && (ls_addr[17:16] == IO_BASE_HI) && io_buffer_full);
    assign grant_ic = ic_elig && (!ls_elig || (last_grant_q == GntLs));
    assign grant_ls = ls_elig && !grant_ic;

    assign abort     = (state_q == StRead) && (owner_q == GntIc) && flush;
    assign last_byte = (cnt_q == (nbytes_q - 3'd1));
    assign read_end  = (cnt_q == nbytes_q);

    // In read cycle k (k >= 1) mem_din carries byte lane k-1.
    assign rd_word = rbuf_q | ({24'd0, mem_din} << {cnt_q - 3'd1, 3'b000});

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= StIdle;
            owner_q      <= GntIc;
            last_grant_q <= GntIc;
            cnt_q        <= 3'd0;
            nbytes_q     <= 3'd0;
            wdata_q      <= 24'd0;
            rbuf_q       <= 32'd0;
            mem_a_q      <= 32'd0;
            mem_dout_q   <= 8'd0;
            mem_wr_q     <= 1'b0;
            ic_done_q    <= 1'b0;
            ls_done_q    <= 1'b0;
            ic_data_q    <= 32'd0;
            ls_rdata_q   <= 32'd0;
        end else if (rdy_in) begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            nbytes_q     <= nbytes_d;
            wdata_q      <= wdata_d;
            rbuf_q       <= rbuf_d;
            mem_a_q      <= mem_a_d;
            mem_dout_q   <= mem_dout_d;
            mem_wr_q     <= mem_wr_d;
            ic_done_q    <= ic_done_d;
            ls_done_q    <= ls_done_d;
            ic_data_q    <= ic_data_d;
            ls_rdata_q   <= ls_rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (grant_ic) begin
                    state_d = StRead;
                end else if (grant_ls) begin
                    state_d = ls_we ? StWrite : StRead;
                end
            end
            StRead: begin
                if (abort || read_end) begin
                    state_d = StIdle;
                end
            end
            StWrite: begin
                if (last_byte) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        nbytes_d     = nbytes_q;
        wdata_d      = wdata_q;
        rbuf_d       = rbuf_q;
        mem_a_d      = mem_a_q;
        mem_dout_d   = mem_dout_q;
        mem_wr_d     = mem_wr_q;
        ic_done_d    = 1'b0;
        ls_done_d    = 1'b0;
        ic_data_d    = ic_data_q;
        ls_rdata_d   = ls_rdata_q;
        unique case (state_q)
            StIdle: begin
                if (grant_ic || grant_ls) begin
                    owner_d      = grant_ic ? GntIc : GntLs;
                    last_grant_d = grant_ic ? GntIc : GntLs;
                    cnt_d        = 3'd0;
                    rbuf_d       = 32'd0;
                    nbytes_d     = grant_ic ? 3'd4 : size_bytes(ls_size);
                    mem_a_d      = grant_ic ? ic_addr : ls_addr;
                    if (grant_ls && ls_we) begin
                        mem_wr_d   = 1'b1;
                        mem_dout_d = ls_wdata[7:0];
                        wdata_d    = ls_wdata[31:8];
                    end
                end
            end
            StRead: begin
                if (abort) begin
                    mem_a_d = 32'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q != 3'd0) begin
                        rbuf_d = rd_word;
                    end
                    // Stop driving the address once the last byte has been issued.
                    mem_a_d = ((cnt_q + 3'd1) < nbytes_q) ? mem_a_q + 32'd1 : 32'd0;
                    if (read_end) begin
                        if (owner_q == GntIc) begin
                            ic_done_d = 1'b1;
                            ic_data_d = rd_word;
                        end else begin
                            ls_done_d  = 1'b1;
                            ls_rdata_d = rd_word;
                        end
                    end
                end
            end
            StWrite: begin
                if (last_byte) begin
                    mem_wr_d   = 1'b0;
                    mem_a_d    = 32'd0;
                    mem_dout_d = 8'd0;
                    ls_done_d  = 1'b1;
                end else begin
                    cnt_d      = cnt_q + 3'd1;
                    mem_a_d    = mem_a_q + 32'd1;
                    mem_dout_d = wdata_q[7:0];
                    wdata_d    = {8'd0, wdata_q[23:8]};
                end
            end
            default: ;
        endcase
    end

    assign mem_a    = mem_a_q;
    assign mem_dout = mem_dout_q;
    assign mem_wr   = mem_wr_q;
    assign ic_done  = ic_done_q;
    assign ic_data  = ic_data_q;
    assign ls_done  = ls_done_q;
    assign ls_rdata = ls_rdata_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sole owner of the byte-wide external memory bus.
- Shares the bus between two requesters: icache word fetch (driven by instruction fetch misses) and the load/store buffer (LSB).
- Serialises multi-byte accesses into byte cycles, assembles read data little-endian, and throttles IO writes on io_buffer_full.
- Discards in-flight icache fetches on a ROB flush.

Parameters:
- IO_BASE_HI, 2'b11, value of addr[17:16] that marks the IO region (0x30000-0x3FFFF).

Ports:
- clk_in  in  1  clock
- rst_in  in  1  synchronous active-high reset
- rdy_in  in  1  global pause when low
- mem_din  in  8  byte read from memory
- mem_dout  out  8  byte to write
- mem_a  out  32  byte address
- mem_wr  out  1  1 = write cycle
- io_buffer_full  in  1  UART buffer full
- flush  in  1  ROB mispredict flush
- ic_req  in  1  icache wants a 4-byte word
- ic_addr  in  32  word address
- ic_done  out  1  one-cycle pulse, ic_data valid
- ic_data  out  32  fetched word
- ls_req  in  1  LSB request
- ls_we  in  1  1 = store
- ls_addr  in  32  byte address
- ls_size  in  2  00 byte, 01 half, 10 word
- ls_wdata  in  32  store data, low bytes used
- ls_done  out  1  one-cycle pulse
- ls_rdata  out  32  load data, zero-extended; the LSB sign-extends

Behaviour:
- Reset: state IDLE; mem_a=0, mem_dout=0, mem_wr=0, ic_done=0, ic_data=0, ls_done=0, ls_rdata=0; last_grant=IC.
- rdy_in low: every register holds. External memory is paused by the same rdy, so no byte is lost.
- States: IDLE, READ, WRITE.
- Request protocol:
  - Requests are level.
  - A requester holds req and operands stable until its done pulse.
  - It drops req in the cycle its done is high.
  - IDLE never grants a requester whose done is high that cycle.
- Arbitration in IDLE:
  - If only one requester is eligible, grant it.
  - If both are eligible, grant the one not equal to last_grant (round robin).
  - last_grant updates on every grant.
- IO stall:
  - An LS store with addr[17:16]==IO_BASE_HI is ineligible while io_buffer_full=1.
  - ic may be granted instead.
- Byte count n: IC=4; LS: size 00→1, 01→2, 10→4.
- On grant:
  - Register mem_a=addr.
  - Store: also register mem_wr=1 and mem_dout=byte0.
  - Load: mem_wr=0.
  - Set byte counter to 0.
- READ:
  - Each cycle mem_a increments until addr+n-1 has been driven.
  - The byte addressed in cycle k is on mem_din in cycle k+1 and is captured into byte lane k at the edge ending cycle k+1.
  - After the last capture: go to IDLE and pulse done.
  - done is visible n+2 cycles after the grant cycle.
- WRITE:
  - Bytes 0..n-1 are driven on consecutive cycles, mem_a=addr+i.
  - After the last byte, mem_wr returns to 0 and done pulses n+1 cycles after the grant.
- mem_wr=0 and mem_a=0 whenever no write or read address is being driven.
- Address arithmetic is 32-bit with wrap.
- flush:
  - Any cycle with an IC transaction active: abort it, go to IDLE next cycle, no ic_done.
  - flush in IDLE suppresses an IC grant that cycle.
  - LS transactions always complete; flush is ignored for them.
  - flush coinciding with ic_done: the pulse still occurs; icache discards it.
- Simultaneous ic_req and ls_req every cycle: grants strictly alternate.
- ic_data and ls_rdata are only updated at the done edge and hold between transactions.

Decomposition:
- const.v gets:
  - size codes SZ_B/SZ_H/SZ_W
  - IO_BASE_HI
  - state encodings ST_IDLE/ST_READ/ST_WRITE
- No sub-module: the byte shifter/assembler is inline, about 250 lines total.

Test Plan:
- Reset then ic_req, addr 0x100, memory holds 0x13,0x05,0x10,0x00 at 0x100-0x103 → ic_done at grant+6, ic_data=0x00100513; mem_a sequence 0x100..0x103.
- ls store word 0xDEADBEEF at 0x200 → mem_wr=1 for 4 cycles, mem_dout EF,BE,AD,DE at 0x200..0x203; ls_done at grant+5.
- ls_req load half 0x202 and ic_req raised the same cycle from reset → LS granted first (last_grant=IC), then IC; a further overlap alternates.
- io_buffer_full=1, ls store byte 0x41 to 0x30000, ic_req pending → IC served, no mem_wr to 0x30000 until full drops; then exactly one write.
- flush asserted in cycle 2 of an IC read → no ic_done, state IDLE next cycle; a pending ls_req is granted the cycle after.
- rdy_in low for 3 cycles mid LS word load → all outputs frozen; ls_rdata correct and done 3 cycles later than nominal; rst_in mid-write → mem_wr=0 next cycle and all outputs at reset values.
